// File: rtl/core_pkg.sv
// Shared constants, word/address types and the dump FSM state encoding
// for the 16x16 register file and its sequential reader.
package core_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 16;

  typedef logic [DATA_W-1:0] reg_word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } dump_state_e;

endpackage

// File: rtl/regfile_dump.sv
// Sequential register-file reader: walks first_addr..last_addr (mod 16) on one
// async read port and streams each word out on a valid/ready channel.
module regfile_dump
  import core_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      start,
  input  logic      abort,
  input  reg_addr_t first_addr,
  input  reg_addr_t last_addr,
  output reg_addr_t rd_addr,
  input  reg_word_t rd_data,
  output logic      out_valid,
  input  logic      out_ready,
  output reg_word_t out_data,
  output reg_addr_t out_addr,
  output logic      out_last,
  output logic      busy,
  output logic      done
);

  dump_state_e state_q, state_d;
  reg_addr_t   ptr_q, ptr_d;
  reg_addr_t   end_q, end_d;
  reg_word_t   data_q, data_d;
  reg_addr_t   addr_q, addr_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Next-state, read-address and output-register load logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    end_d   = end_q;
    data_d  = data_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rd_addr = first_addr;

    case (state_q)
      IDLE: begin
        rd_addr = first_addr;
        // An abort in IDLE also suppresses a coincident start.
        if (start && !abort) begin
          data_d  = rd_data;
          addr_d  = first_addr;
          last_d  = (first_addr == last_addr);
          ptr_d   = first_addr + 4'd1;
          end_d   = last_addr;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        rd_addr = ptr_q;
        if (abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
          busy_d  = 1'b0;
        end else if (valid_q && out_ready) begin
          if (last_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            data_d = rd_data;
            addr_d = ptr_q;
            last_d = (ptr_q == end_q);
            ptr_d  = ptr_q + 4'd1;
          end
        end else begin
          state_d = SEND;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 4'd0;
      end_q   <= 4'd0;
      data_q  <= 16'd0;
      addr_q  <= 4'd0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      end_q   <= end_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_addr  = addr_q;
  assign out_last  = last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Randomized self-checking bench for regfile_dump: a behavioural register file
// and a beat-list reference model derived from the address-range rules.
module tb_regfile_dump;
  import core_pkg::*;

  logic      clk = 1'b0;
  logic      reset, start, abort, out_ready;
  reg_addr_t first_addr, last_addr, rd_addr, out_addr;
  reg_word_t rd_data, out_data;
  logic      out_valid, out_last, busy, done;

  reg_word_t mem [NUM_REGS];
  assign rd_data = mem[rd_addr];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_dump dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .first_addr(first_addr), .last_addr(last_addr), .rd_addr(rd_addr),
    .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .out_last(out_last),
    .busy(busy), .done(done)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic preload();
    for (int i = 0; i < NUM_REGS; i++) mem[i] = 16'h1000 + 16'(i);
  endtask

  int pat [6] = '{1, 0, 0, 1, 0, 1};

  // Caller is at a negedge. mode: 0 ready high, 1 fixed pattern, 2 random
  // ready/writes/stray starts, 3 snapshot writes while beat 2 is stalled.
  // stop_idx >= 0 cancels during that beat (abort, or reset when use_reset).
  task automatic do_dump(input reg_addr_t f, input reg_addr_t l, input int mode,
                         input int stop_idx, input bit use_reset);
    reg_addr_t diff, cur;
    reg_word_t snap;
    int cnt, idx, k, budget;
    bit rdy, stalled;
    diff = l - f;
    cnt = int'(diff) + 1;
    idx = 0; k = 0; budget = 0; stalled = 1'b0;
    first_addr = f; last_addr = l; start = 1'b1; abort = 1'b0;
    #1 chk_eq("idle_rd_addr", 32'(rd_addr), 32'(f));
    cur = f;
    snap = mem[f];
    @(negedge clk);
    start = 1'b0;
    while (1) begin
      chk_eq("valid", 32'(out_valid), 32'd1);
      chk_eq("addr", 32'(out_addr), 32'(cur));
      chk_eq("data", 32'(out_data), 32'(snap));
      chk_eq("last", 32'(out_last), 32'(idx == cnt - 1));
      chk_eq("busy", 32'(busy), 32'd1);
      chk_eq("done_low", 32'(done), 32'd0);
      if (idx == stop_idx) begin
        if (use_reset) reset = 1'b1;
        else abort = 1'b1;
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        reset = 1'b0; abort = 1'b0; out_ready = 1'b0; start = 1'b0;
        chk_eq("cancel_valid", 32'(out_valid), 32'd0);
        chk_eq("cancel_busy", 32'(busy), 32'd0);
        chk_eq("cancel_done", 32'(done), 32'd0);
        chk_eq("cancel_last", 32'(out_last), 32'd0);
        if (use_reset) begin
          chk_eq("rst_data", 32'(out_data), 32'd0);
          chk_eq("rst_addr", 32'(out_addr), 32'd0);
        end
        return;
      end
      case (mode)
        0: rdy = 1'b1;
        1: rdy = pat[k % 6] != 0;
        2: begin
          rdy = ($urandom_range(0, 3) != 0);
          if ($urandom_range(0, 3) == 0) mem[$urandom_range(0, 15)] = 16'($urandom);
          start = 1'($urandom_range(0, 1));
          first_addr = 4'($urandom_range(0, 15));
        end
        3: begin
          rdy = 1'b1;
          if (idx == 2 && !stalled) begin
            rdy = 1'b0;
            mem[2] = 16'hBEEF;
            mem[3] = 16'hCAFE;
            stalled = 1'b1;
          end
        end
        default: rdy = 1'b1;
      endcase
      k++;
      out_ready = rdy;
      if (rdy) begin
        if (idx == cnt - 1) begin
          @(negedge clk);
          out_ready = 1'b0; start = 1'b0;
          chk_eq("end_valid", 32'(out_valid), 32'd0);
          chk_eq("end_busy", 32'(busy), 32'd0);
          chk_eq("end_done", 32'(done), 32'd1);
          return;
        end
        idx++;
        cur = cur + 4'd1;
        snap = mem[cur];
      end
      @(negedge clk);
      budget++;
      if (budget > 200) begin
        chk_eq("timeout", 32'd1, 32'd0);
        return;
      end
    end
  endtask

  initial begin
    reg_addr_t rf, rl;
    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    first_addr = 4'd0; last_addr = 4'd0;
    preload();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_eq("rst_valid", 32'(out_valid), 32'd0);
    chk_eq("rst_busy", 32'(busy), 32'd0);
    chk_eq("rst_done", 32'(done), 32'd0);
    chk_eq("rst_last", 32'(out_last), 32'd0);
    chk_eq("rst_data0", 32'(out_data), 32'd0);
    chk_eq("rst_addr0", 32'(out_addr), 32'd0);

    do_dump(4'd0, 4'd15, 0, -1, 1'b0);
    do_dump(4'd14, 4'd1, 0, -1, 1'b0);   // start lands in the done cycle
    do_dump(4'd5, 4'd5, 0, -1, 1'b0);
    @(negedge clk);
    chk_eq("done_pulse_once", 32'(done), 32'd0);
    do_dump(4'd0, 4'd3, 1, -1, 1'b0);
    do_dump(4'd0, 4'd3, 3, -1, 1'b0);
    preload();
    do_dump(4'd0, 4'd15, 0, 3, 1'b0);
    @(negedge clk);
    chk_eq("abort_no_done", 32'(done), 32'd0);
    do_dump(4'd0, 4'd0, 0, -1, 1'b0);
    do_dump(4'd0, 4'd15, 0, 3, 1'b1);
    do_dump(4'd0, 4'd0, 0, -1, 1'b0);

    // Abort in IDLE blocks a coincident start.
    @(negedge clk);
    first_addr = 4'd7; last_addr = 4'd9; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk_eq("idle_abort_valid", 32'(out_valid), 32'd0);
    chk_eq("idle_abort_busy", 32'(busy), 32'd0);

    for (int n = 0; n < 25; n++) begin
      rf = 4'($urandom_range(0, 15));
      rl = 4'($urandom_range(0, 15));
      do_dump(rf, rl, 2, ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 5)) : -1, 1'b0);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
